shift_in: RTL and testbench

Serial-to-parallel receiver for the multiplier's serial result/operand link.
- Accepts a framed, LSB-first bitstream: one data line plus a frame-valid line, one bit per clk while the frame is asserted.
- Assembles WIDTH bits into a parallel word and presents it with a one-cycle done strobe.
- Flags frames that end early.
- Sits at the receiving end of the serial link, feeding the capture/compare logic and the operand registers of the multiplier datapath.

---
 rtl/shift_in_pkg.sv | 9 +
 rtl/shift_in.sv | 83 ++++++++
 tb/tb_shift_in.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/shift_in_pkg.sv
// shift_in_pkg: state encodings and frame width shared by the serial link ends
package shift_in_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    HOLD = 2'b10
  } state_t;
  localparam int FRAME_WIDTH = 24;
endpackage

// File: rtl/shift_in.sv
// shift_in: framed LSB-first serial-to-parallel receiver with done/err strobes
module shift_in
  import shift_in_pkg::*;
#(
  parameter int WIDTH = FRAME_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z_in,
  input  logic             f_in,
  output logic [WIDTH-1:0] p_out,
  output logic             done,
  output logic             err,
  output logic             busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);
  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_sh, w_sh, r_p, w_p, w_shifted;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_done, w_done, r_err, w_err;
  // New bits enter at the MSB so that after WIDTH shifts bit k holds the k-th sample
  assign w_shifted = (r_sh >> 1) | (WIDTH'(z_in) << (WIDTH - 1));
  always_comb begin
    w_state = r_state;
    w_sh    = r_sh;
    w_cnt   = r_cnt;
    w_p     = r_p;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: if (f_in) begin
        w_sh    = w_shifted;
        w_cnt   = CNT_W'(1);
        w_state = (WIDTH == 1) ? HOLD : RECV;
        w_done  = (WIDTH == 1);
        w_p     = (WIDTH == 1) ? w_shifted : r_p;
      end
      RECV: if (!f_in) begin
        w_err   = 1'b1;
        w_sh    = '0;
        w_cnt   = '0;
        w_state = IDLE;
      end else begin
        w_sh  = w_shifted;
        w_cnt = (r_cnt == FULL) ? r_cnt : r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          w_p     = w_shifted;
          w_done  = 1'b1;
          w_state = HOLD;
        end
      end
      HOLD: if (!f_in) begin
        w_state = IDLE;
        w_sh    = '0;
        w_cnt   = '0;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sh    <= w_sh;
      r_cnt   <= w_cnt;
      r_p     <= w_p;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end
  assign p_out = r_p;
  assign done  = r_done;
  assign err   = r_err;
  assign busy  = (r_state != IDLE);
endmodule

// File: tb/tb_shift_in.sv
// tb_shift_in: directed scenario tasks for the serial-to-parallel receiver
module tb_shift_in;
  logic        clk = 1'b0, reset = 1'b1, z_in = 1'b0, f_in = 1'b0;
  logic [23:0] p_out;
  logic        done, err, busy;
  int          passed = 0, total = 0;
  int          cyc = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;
  logic [23:0] done_val [4];
  int          done_cyc [4];

  shift_in #(.WIDTH(24), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .z_in(z_in), .f_in(f_in),
    .p_out(p_out), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (done) begin
      if (done_cnt < 4) begin
        done_val[done_cnt] = p_out;
        done_cyc[done_cnt] = cyc;
      end
      done_cnt++;
    end
    if (err) err_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic clear_counts();
    done_cnt = 0;
    err_cnt  = 0;
    busy_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      f_in = 1'b1;
      z_in = (i < 24) ? w[i] : 1'b1;
    end
    @(negedge clk);
    f_in = 1'b0;
    z_in = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (p_out !== 24'h0) $display("FAIL reset_p_out got %h want 000000", p_out); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    @(negedge clk);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_full_frame();
    clear_counts();
    drive_frame(24'hA5C3F1, 24);
    total++; if (done !== 1'b1) $display("FAIL full_done_latency got %b want 1", done); else passed++;
    total++; if (p_out !== 24'hA5C3F1) $display("FAIL full_p_out got %h want a5c3f1", p_out); else passed++;
    idle(3);
    total++; if (done_cnt !== 1) $display("FAIL full_done_count got %0d want 1", done_cnt); else passed++;
    total++; if (err_cnt !== 0) $display("FAIL full_err_count got %0d want 0", err_cnt); else passed++;
    total++; if (busy_cnt !== 24) $display("FAIL full_busy_cycles got %0d want 24", busy_cnt); else passed++;
  endtask

  task automatic test_short_frame();
    clear_counts();
    drive_frame(24'h0003FF, 10);
    total++; if (err !== 1'b0) $display("FAIL short_err_early got %b want 0", err); else passed++;
    idle(1);
    total++; if (err !== 1'b1) $display("FAIL short_err_pulse got %b want 1", err); else passed++;
    idle(3);
    total++; if (err_cnt !== 1) $display("FAIL short_err_count got %0d want 1", err_cnt); else passed++;
    total++; if (done_cnt !== 0) $display("FAIL short_done_count got %0d want 0", done_cnt); else passed++;
    total++; if (p_out !== 24'hA5C3F1) $display("FAIL short_p_out_held got %h want a5c3f1", p_out); else passed++;
  endtask

  task automatic test_overlong_frame();
    clear_counts();
    drive_frame(24'h000F0F, 30);
    idle(1);
    total++; if (busy !== 1'b0) $display("FAIL long_back_to_idle busy got %b want 0", busy); else passed++;
    idle(2);
    total++; if (p_out !== 24'h000F0F) $display("FAIL long_p_out got %h want 000f0f", p_out); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL long_done_count got %0d want 1", done_cnt); else passed++;
    total++; if (err_cnt !== 0) $display("FAIL long_err_count got %0d want 0", err_cnt); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      f_in = 1'b1;
      z_in = i[0];
    end
    #2;
    reset = 1'b1;
    f_in  = 1'b0;
    #1;
    total++; if (p_out !== 24'h0) $display("FAIL areset_p_out got %h want 000000", p_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL areset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL areset_strobes got done=%b err=%b want 0 0", done, err); else passed++;
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    clear_counts();
    drive_frame(24'h000001, 24);
    idle(3);
    total++; if (p_out !== 24'h000001) $display("FAIL areset_next_p_out got %h want 000001", p_out); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL areset_next_done_count got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    clear_counts();
    drive_frame(24'h123456, 24);
    drive_frame(24'hFEDCBA, 24);
    idle(3);
    total++; if (done_cnt !== 2) $display("FAIL b2b_done_count got %0d want 2", done_cnt); else passed++;
    if (done_cnt >= 2) begin
      total++; if (done_cyc[1] - done_cyc[0] !== 25) $display("FAIL b2b_spacing got %0d want 25", done_cyc[1] - done_cyc[0]); else passed++;
      total++; if (done_val[0] !== 24'h123456) $display("FAIL b2b_first got %h want 123456", done_val[0]); else passed++;
      total++; if (done_val[1] !== 24'hFEDCBA) $display("FAIL b2b_second got %h want fedcba", done_val[1]); else passed++;
    end
    total++; if (err_cnt !== 0) $display("FAIL b2b_err_count got %0d want 0", err_cnt); else passed++;
  endtask

  task automatic test_glitch();
    clear_counts();
    @(negedge clk);
    f_in = 1'b1;
    z_in = 1'b1;
    @(negedge clk);
    f_in = 1'b0;
    z_in = 1'b0;
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL glitch_err got %b want 1", err); else passed++;
    idle(2);
    drive_frame(24'h800000, 24);
    idle(3);
    total++; if (p_out !== 24'h800000) $display("FAIL glitch_next_p_out got %h want 800000", p_out); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL glitch_next_done_count got %0d want 1", done_cnt); else passed++;
    total++; if (err_cnt !== 1) $display("FAIL glitch_err_count got %0d want 1", err_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_overlong_frame();
    test_async_reset();
    test_back_to_back();
    test_glitch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
